// File: rtl/wave_generator.sv
// Periodic waveform source: saw up/down, triangle or square between latched levels.
// Level/mode/duty settings are captured only at period boundaries; wrap marks each period's last sample.
module wave_generator #(
  parameter  int WIDTH = 12,
  parameter  int STEPS = 100,
  localparam int CW    = $clog2(STEPS)
) (
  input  logic             clock_i,
  input  logic             resetn_i,
  input  logic             enable_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] maximum_i,
  input  logic [WIDTH-1:0] minimum_i,
  input  logic [CW-1:0]    duty_i,
  output logic [WIDTH-1:0] waveform_o,
  output logic             wrap_o
);

  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN} state_t;

  localparam logic [CW-1:0] C_LAST = CW'(STEPS - 1);
  localparam logic [CW-1:0] C_TURN = CW'(STEPS - 2);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  state_t             state_q, state_d;
  logic [CW-1:0]      c_q, c_d;
  logic [WIDTH-1:0]   max_q, min_q, h_q, wave_q, wave_d;
  logic [1:0]         mode_q;
  logic [CW-1:0]      duty_q;
  logic               wrap_q, wrap_d, latch;

  logic [WIDTH-1:0]    span, h_in, f;
  logic [WIDTH+CW-1:0] prod;
  logic                inverted;

  // Step height for the incoming levels; inverted levels collapse to a flat minimum.
  assign inverted = minimum_i > maximum_i;
  assign span     = maximum_i - minimum_i;
  assign h_in     = WIDTH'(32'(span) / (STEPS - 1));

  assign prod = (WIDTH+CW)'(h_q) * (WIDTH+CW)'(c_q);

  always_comb begin
    f = min_q + prod[WIDTH-1:0];
    case (mode_q)
      2'd1:    f = max_q - prod[WIDTH-1:0];
      2'd3:    f = (c_q < duty_q) ? max_q : min_q;
      default: f = min_q + prod[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    wave_d  = wave_q;
    wrap_d  = 1'b0;
    latch   = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      c_d     = '0;
      wave_d  = min_q;
    end else begin
      case (state_q)
        IDLE: begin
          latch   = 1'b1;
          c_d     = '0;
          state_d = RUN_UP;
        end
        RUN_UP: begin
          wave_d = f;
          if (c_q != C_LAST) begin
            c_d = c_q + C_ONE;
          end else if (mode_q == 2'd2) begin
            state_d = RUN_DOWN;
            c_d     = C_TURN;
          end else begin
            c_d    = '0;
            wrap_d = 1'b1;
            latch  = 1'b1;
          end
        end
        RUN_DOWN: begin
          wave_d = f;
          if (c_q != C_ONE) begin
            c_d = c_q - C_ONE;
          end else begin
            c_d     = '0;
            wrap_d  = 1'b1;
            latch   = 1'b1;
            state_d = RUN_UP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      c_q     <= '0;
      wave_q  <= '0;
      wrap_q  <= 1'b0;
      max_q   <= '0;
      min_q   <= '0;
      h_q     <= '0;
      mode_q  <= '0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      wave_q  <= wave_d;
      wrap_q  <= wrap_d;
      if (latch) begin
        mode_q <= mode_i;
        duty_q <= duty_i;
        min_q  <= minimum_i;
        max_q  <= inverted ? minimum_i : maximum_i;
        h_q    <= inverted ? '0 : h_in;
      end
    end
  end

  assign waveform_o = wave_q;
  assign wrap_o     = wrap_q;

endmodule
